// File: rtl/br_pred_unit.sv
// Branch prediction unit: direct-mapped BTB, 2-bit PHT (bimodal or gshare),
// global history register and return address stack, trained at resolution.
module br_pred_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned MODE        = 0,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [XLEN-1:0]     i_f_pc,
  output logic                o_pred_hit,
  output logic                o_pred_taken,
  output logic [XLEN-1:0]     o_pred_target,
  output logic [GHR_BITS-1:0] o_pred_ghr,
  input  logic                i_upd_vld,
  input  logic [XLEN-1:0]     i_upd_pc,
  input  logic [GHR_BITS-1:0] i_upd_ghr,
  input  logic                i_upd_is_br,
  input  logic                i_upd_is_jal,
  input  logic                i_upd_is_jalr,
  input  logic                i_upd_is_call,
  input  logic                i_upd_is_ret,
  input  logic                i_upd_taken,
  input  logic [XLEN-1:0]     i_upd_target,
  input  logic                i_upd_mispred,
  output logic [31:0]         o_br_cnt,
  output logic [31:0]         o_mis_cnt
);

  localparam int unsigned BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned PHT_IDX = $clog2(PHT_ENTRIES);
  localparam int unsigned RAS_IDX = $clog2(RAS_DEPTH);
  localparam int unsigned TAG_W   = XLEN - BTB_IDX - 2;
  localparam bit          GSHARE  = (MODE == 1);

  typedef enum logic [1:0] {
    BT_BR   = 2'd0,
    BT_JAL  = 2'd1,
    BT_JALR = 2'd2,
    BT_RET  = 2'd3
  } btb_kind_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    btb_kind_e        kind;
  } btb_entry_t;

  // History is zero-extended or truncated to the PHT index width by the cast.
  function automatic logic [PHT_IDX-1:0] pht_index(input logic [XLEN-1:0]     pc,
                                                    input logic [GHR_BITS-1:0] hist);
    logic [PHT_IDX-1:0] hist_fit;
    hist_fit  = PHT_IDX'(hist);
    pht_index = pc[PHT_IDX+1:2] ^ (GSHARE ? hist_fit : {PHT_IDX{1'b0}});
  endfunction

  logic [BTB_ENTRIES-1:0] btb_vld;
  btb_entry_t             btb_mem [BTB_ENTRIES];
  logic [1:0]             pht     [PHT_ENTRIES];
  logic [GHR_BITS-1:0]    ghr;
  logic [XLEN-1:0]        ras_mem [RAS_DEPTH];
  logic [RAS_IDX-1:0]     ras_ptr;
  logic [RAS_IDX:0]       ras_cnt;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{i_f_pc[1:0], i_upd_pc[1:0]};

  // ---------------- prediction (combinational off fetch PC) ----------------
  logic [BTB_IDX-1:0] f_bidx;
  logic [PHT_IDX-1:0] f_pidx;
  btb_entry_t         f_ent;
  logic               f_hit;
  logic               f_taken;
  logic               ras_empty;
  logic               ras_full;
  logic [RAS_IDX-1:0] ras_top_idx;
  logic [XLEN-1:0]    ras_top;

  assign f_bidx      = i_f_pc[BTB_IDX+1:2];
  assign f_pidx      = pht_index(i_f_pc, ghr);
  assign f_ent       = btb_mem[f_bidx];
  assign f_hit       = btb_vld[f_bidx] && (f_ent.tag == i_f_pc[XLEN-1:BTB_IDX+2]);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == (RAS_IDX+1)'(RAS_DEPTH));
  assign ras_top_idx = ras_ptr - RAS_IDX'(1);
  assign ras_top     = ras_mem[ras_top_idx];

  always_comb begin
    f_taken = 1'b1;
    if (f_ent.kind == BT_BR) f_taken = pht[f_pidx][1];
  end

  assign o_pred_hit    = i_rst_n & f_hit;
  assign o_pred_taken  = i_rst_n & f_hit & f_taken;
  assign o_pred_target = ((f_ent.kind == BT_RET) && !ras_empty) ? ras_top : f_ent.target;
  assign o_pred_ghr    = ghr;

  // ---------------- update decode ----------------
  logic [BTB_IDX-1:0] u_bidx;
  logic [PHT_IDX-1:0] u_pidx;
  logic               btb_we;
  logic               pht_we;
  btb_kind_e          u_kind;
  logic [1:0]         pht_cur;
  logic [1:0]         pht_nxt;
  logic [XLEN-1:0]    ras_push_val;

  assign u_bidx       = i_upd_pc[BTB_IDX+1:2];
  assign u_pidx       = pht_index(i_upd_pc, i_upd_ghr);
  assign btb_we       = i_upd_vld & i_upd_taken &
                        (i_upd_is_br | i_upd_is_jal | i_upd_is_jalr | i_upd_is_ret);
  assign pht_we       = i_upd_vld & i_upd_is_br;
  assign pht_cur      = pht[u_pidx];
  assign ras_push_val = i_upd_pc + XLEN'(4);

  always_comb begin
    u_kind = BT_BR;
    if (i_upd_is_ret)       u_kind = BT_RET;
    else if (i_upd_is_jalr) u_kind = BT_JALR;
    else if (i_upd_is_jal)  u_kind = BT_JAL;
  end

  // Saturating 2-bit counter step.
  always_comb begin
    pht_nxt = pht_cur;
    if (i_upd_taken) begin
      if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
    end
  end

  // RAS: call+ret replaces the top; a push when full overwrites the oldest slot.
  logic               ras_we;
  logic [RAS_IDX-1:0] ras_wr_idx;
  logic [RAS_IDX-1:0] ras_ptr_nxt;
  logic [RAS_IDX:0]   ras_cnt_nxt;

  always_comb begin
    ras_we      = 1'b0;
    ras_wr_idx  = ras_ptr;
    ras_ptr_nxt = ras_ptr;
    ras_cnt_nxt = ras_cnt;
    if (i_upd_vld) begin
      if (i_upd_is_call && i_upd_is_ret && !ras_empty) begin
        ras_we     = 1'b1;
        ras_wr_idx = ras_top_idx;
      end else if (i_upd_is_call) begin
        ras_we      = 1'b1;
        ras_wr_idx  = ras_ptr;
        ras_ptr_nxt = ras_ptr + RAS_IDX'(1);
        if (!ras_full) ras_cnt_nxt = ras_cnt + (RAS_IDX+1)'(1);
      end else if (i_upd_is_ret && !ras_empty) begin
        ras_ptr_nxt = ras_top_idx;
        ras_cnt_nxt = ras_cnt - (RAS_IDX+1)'(1);
      end
    end
  end

  // ---------------- state with reset ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btb_vld   <= '0;
      pht       <= '{default: 2'b01};
      ghr       <= '0;
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      o_br_cnt  <= '0;
      o_mis_cnt <= '0;
    end else begin
      if (btb_we) btb_vld[u_bidx] <= 1'b1;
      if (pht_we) begin
        pht[u_pidx] <= pht_nxt;
        ghr         <= GHR_BITS'({ghr, i_upd_taken});
      end
      ras_ptr <= ras_ptr_nxt;
      ras_cnt <= ras_cnt_nxt;
      if (i_upd_vld) begin
        o_br_cnt <= o_br_cnt + 32'd1;
        if (i_upd_mispred) o_mis_cnt <= o_mis_cnt + 32'd1;
      end
    end
  end

  // Payload storage; valid bits and RAS count qualify it, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && btb_we) begin
      btb_mem[u_bidx] <= '{tag:    i_upd_pc[XLEN-1:BTB_IDX+2],
                           target: i_upd_target,
                           kind:   u_kind};
    end
    if (i_rst_n && ras_we) ras_mem[ras_wr_idx] <= ras_push_val;
  end

endmodule

// File: tb/tb_br_pred_unit.sv
// Directed bench for br_pred_unit: bimodal and gshare instances share stimulus;
// expectations are queued by stimulus and checked by a negedge monitor.
module tb_br_pred_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        upd_vld, upd_is_br, upd_is_jal, upd_is_jalr, upd_is_call, upd_is_ret;
  logic        upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_ghr;

  logic        hit0, tk0, hit1, tk1;
  logic [31:0] tgt0, tgt1, bcnt0, mcnt0, bcnt1, mcnt1;
  logic [7:0]  ghr0, ghr1;

  always #5 clk = ~clk;

  br_pred_unit #(.MODE(0)) u_bim (
    .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc),
    .o_pred_hit(hit0), .o_pred_taken(tk0), .o_pred_target(tgt0), .o_pred_ghr(ghr0),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_ghr(upd_ghr),
    .i_upd_is_br(upd_is_br), .i_upd_is_jal(upd_is_jal), .i_upd_is_jalr(upd_is_jalr),
    .i_upd_is_call(upd_is_call), .i_upd_is_ret(upd_is_ret), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_mispred(upd_mispred),
    .o_br_cnt(bcnt0), .o_mis_cnt(mcnt0));

  br_pred_unit #(.MODE(1)) u_gsh (
    .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc),
    .o_pred_hit(hit1), .o_pred_taken(tk1), .o_pred_target(tgt1), .o_pred_ghr(ghr1),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_ghr(upd_ghr),
    .i_upd_is_br(upd_is_br), .i_upd_is_jal(upd_is_jal), .i_upd_is_jalr(upd_is_jalr),
    .i_upd_is_call(upd_is_call), .i_upd_is_ret(upd_is_ret), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_mispred(upd_mispred),
    .o_br_cnt(bcnt1), .o_mis_cnt(mcnt1));

  typedef struct {
    int          sel;
    bit          is_cnt;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghr;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;
  } exp_t;

  exp_t  sb[$];
  string name_q[$];
  logic  chk_stb = 1'b0;
  int    n_run   = 0;
  int    n_fail  = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per strobed sample.
  exp_t        cur;
  string       cur_nm;
  logic        a_hit, a_tk;
  logic [31:0] a_tgt;
  logic [7:0]  a_ghr;
  always @(negedge clk) begin
    if (chk_stb) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        cur    = sb.pop_front();
        cur_nm = name_q.pop_front();
        if (cur.is_cnt) begin
          cmp({cur_nm, ".br_cnt"}, bcnt0, cur.br_cnt);
          cmp({cur_nm, ".mis_cnt"}, mcnt0, cur.mis_cnt);
        end else begin
          if (cur.sel == 0) begin
            a_hit = hit0; a_tk = tk0; a_tgt = tgt0; a_ghr = ghr0;
          end else begin
            a_hit = hit1; a_tk = tk1; a_tgt = tgt1; a_ghr = ghr1;
          end
          cmp({cur_nm, ".hit"}, 32'(a_hit), 32'(cur.hit));
          cmp({cur_nm, ".taken"}, 32'(a_tk), 32'(cur.taken));
          cmp({cur_nm, ".ghr"}, 32'(a_ghr), 32'(cur.ghr));
          if (cur.hit) cmp({cur_nm, ".target"}, a_tgt, cur.target);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    chk_stb = 1'b1;
    @(negedge clk);
    #1;
    chk_stb = 1'b0;
  endtask

  task automatic chk_pred(input int sel, input string nm, input logic [31:0] pc,
                          input logic hit, input logic tk, input logic [31:0] tgt,
                          input logic [7:0] g);
    exp_t e;
    f_pc     = pc;
    e.sel    = sel;
    e.is_cnt = 1'b0;
    e.hit    = hit;
    e.taken  = tk;
    e.target = tgt;
    e.ghr    = g;
    e.br_cnt = '0;
    e.mis_cnt = '0;
    sb.push_back(e);
    name_q.push_back(nm);
    strobe();
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] br, input logic [31:0] mis);
    exp_t e;
    e.sel     = 0;
    e.is_cnt  = 1'b1;
    e.hit     = 1'b0;
    e.taken   = 1'b0;
    e.target  = '0;
    e.ghr     = '0;
    e.br_cnt  = br;
    e.mis_cnt = mis;
    sb.push_back(e);
    name_q.push_back(nm);
    strobe();
  endtask

  task automatic upd_drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] g,
                           input logic br, input logic jal, input logic jalr,
                           input logic call, input logic ret, input logic tk, input logic mis);
    upd_pc = pc; upd_target = tgt; upd_ghr = g;
    upd_is_br = br; upd_is_jal = jal; upd_is_jalr = jalr;
    upd_is_call = call; upd_is_ret = ret; upd_taken = tk; upd_mispred = mis;
    upd_vld = 1'b1;
  endtask

  task automatic upd_idle();
    upd_vld = 1'b0;
    upd_is_br = 1'b0; upd_is_jal = 1'b0; upd_is_jalr = 1'b0;
    upd_is_call = 1'b0; upd_is_ret = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] g,
                     input logic br, input logic jal, input logic jalr,
                     input logic call, input logic ret, input logic tk, input logic mis);
    upd_drive(pc, tgt, g, br, jal, jalr, call, ret, tk, mis);
    step();
    upd_idle();
  endtask

  task automatic upd_br(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic [7:0] g);
    upd(pc, tgt, g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tk, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; f_pc = 32'h0; upd_pc = '0; upd_target = '0; upd_ghr = '0;
    upd_idle();
    step(); step();
    rst_n = 1'b1;

    // Reset state
    chk_pred(0, "t1_reset", 32'h100, 1'b0, 1'b0, 32'h0, 8'h00);
    chk_cnt("t1_cnt", 32'd0, 32'd0);

    // JAL allocation and tag alias
    upd(32'h100, 32'h200, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_pred(0, "t2_hit", 32'h100, 1'b1, 1'b1, 32'h200, 8'h00);
    chk_pred(0, "t2_alias", 32'h4100, 1'b0, 1'b0, 32'h0, 8'h00);

    // Bimodal counter walk incl. both saturation points
    do_reset();
    upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    chk_pred(0, "t3_t1", 32'h40, 1'b1, 1'b1, 32'h80, 8'h01);
    upd_br(32'h40, 32'h80, 1'b0, 8'h00);
    upd_br(32'h40, 32'h80, 1'b0, 8'h00);
    chk_pred(0, "t3_nt2", 32'h40, 1'b1, 1'b0, 32'h80, 8'h04);
    upd_br(32'h40, 32'h80, 1'b0, 8'h00);
    chk_pred(0, "t3_sat00", 32'h40, 1'b1, 1'b0, 32'h80, 8'h08);
    for (int i = 0; i < 3; i++) upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    chk_pred(0, "t3_t3", 32'h40, 1'b1, 1'b1, 32'h80, 8'h47);
    upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    upd_br(32'h40, 32'h80, 1'b0, 8'h00);
    chk_pred(0, "t3_sat11", 32'h40, 1'b1, 1'b1, 32'h80, 8'h1E);

    // Return address stack
    do_reset();
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_ret_empty", 32'h300, 1'b1, 1'b1, 32'h14, 8'h00);
    for (int i = 1; i <= 5; i++)
      upd(32'(i * 16), 32'h1000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_pred(0, "t4_pop0", 32'h300, 1'b1, 1'b1, 32'h54, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_pop1", 32'h300, 1'b1, 1'b1, 32'h44, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_pop2", 32'h300, 1'b1, 1'b1, 32'h34, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_pop3", 32'h300, 1'b1, 1'b1, 32'h24, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_empty", 32'h300, 1'b1, 1'b1, 32'h14, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    upd(32'h60, 32'h1000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_pred(0, "t4_underflow", 32'h300, 1'b1, 1'b1, 32'h64, 8'h00);
    upd(32'h70, 32'h1000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_callret", 32'h300, 1'b1, 1'b1, 32'h74, 8'h00);
    upd(32'h300, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_pred(0, "t4_callret_pop", 32'h300, 1'b1, 1'b1, 32'h14, 8'h00);

    // Gshare: same PC, outcome selected by history
    do_reset();
    upd_br(32'h40, 32'h80, 1'b0, 8'h01);
    upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    chk_pred(1, "t5_ghr01", 32'h40, 1'b1, 1'b0, 32'h80, 8'h01);
    for (int i = 0; i < 8; i++) upd_br(32'h3FC, 32'h500, 1'b0, 8'h00);
    chk_pred(1, "t5_ghr00", 32'h40, 1'b1, 1'b1, 32'h80, 8'h00);

    // Same-cycle update/fetch, counters, reset overriding an update
    do_reset();
    upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    upd_drive(32'h40, 32'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_pred(0, "t6_same_old", 32'h40, 1'b1, 1'b1, 32'h80, 8'h01);
    step();
    upd_idle();
    chk_pred(0, "t6_same_new", 32'h40, 1'b1, 1'b0, 32'h80, 8'h02);
    upd_br(32'h40, 32'h80, 1'b1, 8'h00);
    chk_pred(0, "t6_third", 32'h40, 1'b1, 1'b1, 32'h80, 8'h05);
    chk_cnt("t6_cnt", 32'd3, 32'd1);
    step();
    rst_n = 1'b0;
    upd_drive(32'h40, 32'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_pred(0, "t6_rst_gate", 32'h40, 1'b0, 1'b0, 32'h0, 8'h05);
    step();
    upd_idle();
    rst_n = 1'b1;
    chk_pred(0, "t6_rst_clear", 32'h40, 1'b0, 1'b0, 32'h0, 8'h00);
    chk_cnt("t6_rst_cnt", 32'd0, 32'd0);

    step();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
